// File: rtl/add_seq8_pkg.sv
// Shared constants for the byte-serial add/subtract sequencer.
// State encoding and byte width used by the controller and its adder slice.
package add_seq8_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/ripple8.sv
// 8-bit ripple-carry adder: s = a + b + cin, purely combinational.
// Zero latency, no flow control; the carry chain is the sequencer's critical path.
module ripple8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       co
);

    logic c;

    always_comb begin
        s = '0;
        c = cin;
        for (int i = 0; i < 8; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/add_seq8.sv
// Multi-byte add/subtract using one shared 8-bit adder, LSB byte first.
// Latency NBYTES cycles from accept to res_valid; result held until res_ready, no request queueing.
module add_seq8
    import add_seq8_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_valid,
    output logic                       start_ready,
    input  logic [BYTE_W*NBYTES-1:0]   a,
    input  logic [BYTE_W*NBYTES-1:0]   b,
    input  logic                       cin,
    input  logic                       sub,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [BYTE_W*NBYTES-1:0]   sum,
    output logic                       cout,
    output logic                       ovf
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [BYTE_W-1:0] a_byte, b_byte, s_byte;
    logic              co_byte;

    // Byte select for the shared adder
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (idx_q == IW'(k)) begin
                a_byte = a_q[BYTE_W*k +: BYTE_W];
                b_byte = b_q[BYTE_W*k +: BYTE_W];
            end
        end
    end

    ripple8 u_ripple8 (
        .a   (a_byte),
        .b   (b_byte),
        .cin (carry_q),
        .s   (s_byte),
        .co  (co_byte)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub | cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (idx_q == IW'(k)) begin
                        sum_d[BYTE_W*k +: BYTE_W] = s_byte;
                    end
                end
                carry_d = co_byte;
                // Subtract folds into add via ~b and carry-in 1, so one overflow rule covers both.
                if (idx_q == LAST_IDX) begin
                    cout_d  = co_byte;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (s_byte[BYTE_W-1] != a_q[W-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_add_seq8.sv
// Bench for add_seq8 (NBYTES=4): directed test-plan cases plus random operands
// checked against an integer-arithmetic reference model.
module tb_add_seq8;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         cout, ovf;

    int checks = 0;
    int errors = 0;

    add_seq8 #(.NBYTES(NB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .sub         (sub),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full width.
    task automatic ref_model(input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic cv, input logic sv,
                             output logic [W-1:0] s, output logic co, output logic ov);
        longint unsigned u;
        longint          r;
        if (sv) begin
            u  = longint'(av) - longint'(bv);
            co = (av >= bv);
            r  = longint'($signed(av)) - longint'($signed(bv));
        end else begin
            u  = longint'(av) + longint'(bv) + longint'(cv);
            co = u[W];
            r  = longint'($signed(av)) + longint'($signed(bv)) + longint'(cv);
        end
        s  = u[W-1:0];
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic sv,
                          input logic [W-1:0] es, input logic eco, input logic eov,
                          input int stall);
        int n;
        n = 0;
        while (!start_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_start_ready"}, 64'(start_ready), 64'(1));
        a = av; b = bv; cin = cv; sub = sv;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = $urandom; b = $urandom; cin = $urandom_range(0, 1); sub = $urandom_range(0, 1);
        for (int i = 1; i <= NB; i++) begin
            @(posedge clk); #1;
            chk({tag, "_latency_valid"}, 64'(res_valid), 64'(i == NB));
        end
        chk({tag, "_busy_ready"}, 64'(start_ready), 64'(0));
        chk({tag, "_sum"}, 64'(sum), 64'(es));
        chk({tag, "_cout"}, 64'(cout), 64'(eco));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eov));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, "_stall_sum"}, 64'(sum), 64'(es));
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({tag, "_back_idle"}, 64'(start_ready), 64'(1));
        chk({tag, "_valid_drop"}, 64'(res_valid), 64'(0));
    endtask

    logic [W-1:0] es;
    logic         eco, eov;
    logic [W-1:0] ra, rb;
    logic         rc, rs;

    initial begin
        rst_n = 1'b0;
        start_valid = 1'b0; res_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1;
        chk("reset_start_ready", 64'(start_ready), 64'(1));
        chk("reset_res_valid", 64'(res_valid), 64'(0));
        chk("reset_sum", 64'(sum), 64'(0));
        chk("reset_cout_ovf", {62'd0, cout, ovf}, 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready", 64'(start_ready), 64'(1));

        run_op("add12", 32'd12, 32'd12, 1'b0, 1'b0, 32'd24, 1'b0, 1'b0, 0);
        run_op("add15c", 32'd15, 32'd5, 1'b1, 1'b0, 32'd21, 1'b0, 1'b0, 0);
        run_op("ripple", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 0);
        run_op("byte_cross", 32'h0000_00FF, 32'd1, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 0);
        run_op("sovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0);
        run_op("sub5_7", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0);
        run_op("sub40", 32'd40, 32'd40, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 0);

        // Backpressure: hold DONE while new requests are offered.
        a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0;
        start_valid = 1'b1;
        @(posedge clk); #1;
        repeat (NB) @(posedge clk);
        #1;
        chk("bp_valid", 64'(res_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom; start_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp_sum_hold", 64'(sum), 64'(32'h2345_6789));
            chk("bp_flags_hold", {62'd0, cout, ovf}, 64'(0));
            chk("bp_not_ready", 64'(start_ready), 64'(0));
            chk("bp_valid_hold", 64'(res_valid), 64'(1));
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("bp_release_ready", 64'(start_ready), 64'(1));
        chk("bp_release_valid", 64'(res_valid), 64'(0));

        // Reset abort with idx=2 in RUN.
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; sub = 1'b0;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_pre_sum_partial", 64'(sum[15:0]), 64'(16'hFFFF));
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 64'(start_ready), 64'(1));
        chk("abort_valid", 64'(res_valid), 64'(0));
        chk("abort_sum", 64'(sum), 64'(0));
        chk("abort_flags", {62'd0, cout, ovf}, 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_still_idle", 64'(res_valid), 64'(0));
        run_op("after_abort", 32'd7, 32'd10, 1'b1, 1'b0, 32'd18, 1'b0, 1'b0, 0);

        for (int t = 0; t < 24; t++) begin
            ra = $urandom; rb = $urandom;
            if (t % 4 == 0) rb = ra ^ 32'h8000_0000;
            rc = $urandom_range(0, 1); rs = $urandom_range(0, 1);
            ref_model(ra, rb, rc, rs, es, eco, eov);
            run_op("rand", ra, rb, rc, rs, es, eco, eov, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
